ram_capture_buffer: RTL and testbench

- Parametrised multi-channel circular sample memory with pre/post-trigger capture and sequential readout, oldest sample first.
- Successor to the plain 512x8 dual-port RAM: adds channel count, a capture state machine, wrap-around write pointer, pre-trigger depth control and a valid-flagged read port.
- Sits between the ADC sample path and the readout/host interface.
- Single clock domain.

---
 rtl/ram_capture_buffer.sv | 115 +++++++++++
 tb/tb_ram_capture_buffer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_capture_buffer.sv
// Multi-channel circular capture memory: pre/post-trigger acquisition into a
// wrap-around buffer, then sequential readout starting at the oldest sample.
module ram_capture_buffer #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           arm,
  input  logic [ADDR_WIDTH-1:0]          pre_count,
  input  logic [CHANNELS*DATA_WIDTH-1:0] din,
  input  logic                           din_valid,
  input  logic                           trigger,
  input  logic                           rd_en,
  output logic [CHANNELS*DATA_WIDTH-1:0] dout,
  output logic                           dout_valid,
  output logic                           rd_last,
  output logic                           armed,
  output logic                           triggered,
  output logic                           ready
);

  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int WORD_WIDTH = CHANNELS * DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   ONE_L    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   ZERO_L   = '0;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

  state_t state, state_next;

  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr, pre_r, rd_idx, rd_addr;
  logic [ADDR_WIDTH:0]   fill, post_left, post_init;
  logic                  wr_en, trig_q, rd_fire, rd_final;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    wr_en      = !arm && din_valid && (state == ARMED || state == POST);
    trig_q     = !arm && din_valid && trigger && (state == ARMED) &&
                 (fill >= {1'b0, pre_r});
    post_init  = DEPTH_L - {1'b0, pre_r} - ONE_L;
    rd_fire    = !arm && rd_en && (state == DONE);
    rd_final   = rd_fire && (rd_idx == LAST_IDX);
    // wptr is frozen in DONE and already points at the oldest sample.
    rd_addr    = wptr + rd_idx;

    if (arm) begin
      state_next = ARMED;
    end else begin
      unique case (state)
        IDLE:  state_next = IDLE;
        ARMED: if (trig_q) state_next = (post_init == ZERO_L) ? DONE : POST;
        POST:  if (wr_en && post_left == ONE_L) state_next = DONE;
        DONE:  if (rd_final) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      fill       <= '0;
      pre_r      <= '0;
      post_left  <= '0;
      rd_idx     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      rd_last    <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      rd_last    <= 1'b0;
      if (arm) begin
        wptr   <= '0;
        fill   <= '0;
        pre_r  <= pre_count;
        rd_idx <= '0;
      end else begin
        if (wr_en) begin
          wptr <= wptr + 1'b1;
          if (fill != DEPTH_L) fill <= fill + ONE_L;
        end
        if (trig_q) post_left <= post_init;
        else if (wr_en && state == POST) post_left <= post_left - ONE_L;
        if (rd_fire) begin
          dout       <= mem[rd_addr];
          dout_valid <= 1'b1;
          rd_last    <= rd_final;
          rd_idx     <= rd_idx + 1'b1;
        end
      end
    end
  end

  // NOTE: the sample array has no reset; its contents are only meaningful after a full capture.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= din;
  end

  assign armed     = (state == ARMED);
  assign triggered = (state == POST);
  assign ready     = (state == DONE);

endmodule

// File: tb/tb_ram_capture_buffer.sv
// Scoreboard bench for ram_capture_buffer: directed captures, readout pushed to a
// queue by the stimulus and popped by an independent monitor on dout_valid.
module tb_ram_capture_buffer;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int CH = 2;
  localparam int WW = DW * CH;

  logic          clk = 1'b0;
  logic          rst, arm, din_valid, trigger, rd_en;
  logic [AW-1:0] pre_count;
  logic [WW-1:0] din, dout;
  logic          dout_valid, rd_last, armed, triggered, ready;

  typedef struct {
    logic [WW-1:0] data;
    logic          last;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   cycle = 0;
  int   tests = 0;
  int   fails = 0;

  ram_capture_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .arm(arm), .pre_count(pre_count), .din(din),
    .din_valid(din_valid), .trigger(trigger), .rd_en(rd_en), .dout(dout),
    .dout_valid(dout_valid), .rd_last(rd_last), .armed(armed),
    .triggered(triggered), .ready(ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [WW-1:0] word(int n);
    logic [7:0] b;
    b = n[7:0];
    return {~b, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented sample must match the oldest outstanding request,
  // arriving exactly one cycle after it was issued.
  always @(negedge clk) begin
    if (dout_valid) begin
      check("valid_has_request", q.size() > 0, 1);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("dout", dout, e.data);
        check("rd_last", rd_last, e.last);
        check("valid_latency", cycle, e.cyc);
      end
    end
  end

  task automatic check_idle_outputs(string tag);
    check({tag, "_armed"}, armed, 0);
    check({tag, "_triggered"}, triggered, 0);
    check({tag, "_ready"}, ready, 0);
  endtask

  task automatic arm_cap(int pre);
    arm = 1'b1;
    pre_count = pre[AW-1:0];
    tick();
    arm = 1'b0;
    check("arm_armed", armed, 1);
    check("arm_triggered", triggered, 0);
    check("arm_ready", ready, 0);
    check("arm_dout_valid", dout_valid, 0);
  endtask

  // Stream samples n=first.. until ready or n passes stop. Status is checked after
  // every write against the hand-computed accept/done sample numbers.
  task automatic capture(int first, int stop, int acc_n, int done_n, int ign_n, bit gap);
    int n;
    n = first;
    while (n <= stop && !ready) begin
      din = word(n);
      din_valid = 1'b1;
      trigger = (n == acc_n) || (n == ign_n);
      tick();
      din_valid = 1'b0;
      trigger = 1'b0;
      check("cap_armed", armed, n < acc_n);
      check("cap_triggered", triggered, (n >= acc_n) && (n < done_n));
      check("cap_ready", ready, n >= done_n);
      if (gap) begin
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
      end
      n++;
    end
    if (done_n <= stop) check("done_sample", n - 1, done_n);
  endtask

  task automatic readout(int first, int nreads, int gap);
    for (int i = 0; i < nreads; i++) begin
      rd_en = 1'b1;
      q.push_back('{data: word(first + i), last: (i == 15), cyc: cycle + 1});
      tick();
      rd_en = 1'b0;
      repeat (gap) tick();
    end
    repeat (2) tick();
    check("rd_drain", q.size(), 0);
    if (nreads == 16) begin
      check("post_rd_ready", ready, 0);
      check("post_rd_armed", armed, 0);
      check("dout_hold", dout, word(first + 15));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; arm = 1'b0; pre_count = '0; din = '0;
    din_valid = 1'b0; trigger = 1'b0; rd_en = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_rd_last", rd_last, 0);
    check_idle_outputs("rst");

    // Basic pre-trigger: readout 6..21, trigger sample 10 at index 4.
    arm_cap(4);
    capture(0, 60, 10, 21, -1, 1'b0);
    readout(6, 16, 0);

    // Early trigger at n=3 is unqualified (fill < 8).
    arm_cap(8);
    capture(0, 60, 12, 19, 3, 1'b0);
    readout(4, 16, 0);

    // Zero pre-trigger depth.
    arm_cap(0);
    capture(0, 60, 0, 15, -1, 1'b0);
    readout(0, 16, 0);

    // Maximum pre-trigger depth: trigger sample completes the capture.
    arm_cap(15);
    capture(0, 60, 20, 20, -1, 1'b0);
    readout(5, 16, 0);

    // Gapped stream with trigger held during gaps, throttled reads.
    arm_cap(4);
    capture(0, 60, 10, 21, -1, 1'b1);
    readout(6, 16, 2);

    // Re-arm mid-POST, then a fresh capture.
    arm_cap(4);
    capture(0, 14, 10, 21, -1, 1'b0);
    check("mid_post_triggered", triggered, 1);
    arm_cap(2);
    capture(100, 160, 105, 118, -1, 1'b0);
    readout(103, 16, 0);

    // Re-arm mid-readout with a same-cycle read request.
    arm_cap(4);
    capture(0, 60, 10, 21, -1, 1'b0);
    readout(6, 5, 0);
    rd_en = 1'b1; arm = 1'b1; pre_count = '0;
    tick();
    rd_en = 1'b0; arm = 1'b0;
    check("abort_rd_dout_valid", dout_valid, 0);
    check("abort_rd_armed", armed, 1);
    check("abort_rd_ready", ready, 0);

    // arm with a same-cycle qualified-looking trigger: trigger must be ignored.
    arm = 1'b1; pre_count = '0; din = word(77); din_valid = 1'b1; trigger = 1'b1;
    tick();
    arm = 1'b0; din_valid = 1'b0; trigger = 1'b0;
    check("arm_trig_armed", armed, 1);
    check("arm_trig_triggered", triggered, 0);
    capture(50, 110, 50, 65, -1, 1'b0);
    readout(50, 16, 0);

    // Synchronous reset during POST; inputs ignored until the next arm.
    arm_cap(4);
    capture(0, 12, 10, 21, -1, 1'b0);
    rst = 1'b1; rd_en = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_dout", dout, 0);
    check("midrst_dout_valid", dout_valid, 0);
    check("midrst_rd_last", rd_last, 0);
    check_idle_outputs("midrst");
    din = word(200); din_valid = 1'b1; trigger = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_idle_outputs("idle_ignore");
    end
    rd_en = 1'b0; din_valid = 1'b0; trigger = 1'b0;
    repeat (2) tick();
    arm_cap(4);
    capture(0, 60, 10, 21, -1, 1'b0);
    readout(6, 16, 0);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
